adder_share_arbiter: RTL and testbench

//  Round-robin arbiter/scheduler sharing one W-bit ripple/prefix adder slice among NREQ requesters.

---
 rtl/adder_share_arbiter_pkg.sv | 13 +
 rtl/adder_share_arbiter_if.sv | 29 ++
 rtl/adder_share_arbiter_rr_grant.sv | 32 +++
 rtl/adder_share_arbiter.sv | 118 +++++++++++
 tb/tb_adder_share_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the adder-sharing round-robin arbiter.
package adder_share_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  localparam int unsigned NREQ_MAX = 8;

  // Next round-robin position after index g, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester/response handshake bundle for adder_share_arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_chain;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/adder_share_arbiter_rr_grant.sv
// Round-robin pick: lowest valid index at or after ptr_i, wrapping to 0.
module rr_grant
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         valid_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);
  localparam int unsigned IDW = $clog2(NREQ);

  int unsigned cur;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cur     = 32'(ptr_i);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_o && valid_i[IDW'(cur)]) begin
        any_o                = 1'b1;
        grant_o[IDW'(cur)]   = 1'b1;
        idx_o                = IDW'(cur);
      end
      cur = rr_next(cur, NREQ);
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one W-bit adder among NREQ requesters, 1-cycle registered response.
// Optional carry chaining with lane lock enabled by ADDER_CHAIN_EN.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_share_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  arb_state_e      state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  owner_q;
  logic            carry_q;
  logic            rsp_valid_q;
  logic [W-1:0]    rsp_sum_q;
  logic            rsp_cout_q;
  logic [IDW-1:0]  rsp_id_q;

  logic            slot_free;
  logic            issue;
  logic            cin_sel;
  logic            chain_bit;
  logic [NREQ-1:0] owner_mask;
  logic [NREQ-1:0] arb_valid;
  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W:0]      sum_full;

  // Lock state exists in both builds; without chaining it can never be entered.
`ifdef ADDER_CHAIN_EN
  assign chain_bit = bus.req_chain[gnt_idx];
`else
  logic unused_chain;
  assign unused_chain = ^bus.req_chain;
  assign chain_bit    = 1'b0;
`endif

  always_comb begin
    slot_free  = !rsp_valid_q || bus.rsp_ready;
    owner_mask = '0;
    owner_mask[owner_q] = 1'b1;
    arb_valid  = bus.req_valid & {NREQ{slot_free}};
    if (state_q == LOCKED) arb_valid = arb_valid & owner_mask;
  end

  rr_grant #(.NREQ(NREQ)) u_rr_grant (
    .valid_i (arb_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt_onehot),
    .idx_o   (gnt_idx),
    .any_o   (issue)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_onehot[i]) begin
        op_a = bus.req_a[i*W +: W];
        op_b = bus.req_b[i*W +: W];
      end
    end
    cin_sel  = (state_q == LOCKED) ? carry_q : bus.req_cin[gnt_idx];
    sum_full = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin_sel};
  end

  assign bus.req_ready = gnt_onehot;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else if (issue) begin
      rsp_valid_q <= 1'b1;
      rsp_sum_q   <= sum_full[W-1:0];
      rsp_cout_q  <= sum_full[W];
      rsp_id_q    <= gnt_idx;
      ptr_q       <= IDW'(rr_next(32'(gnt_idx), NREQ));
      unique case (state_q)
        IDLE: begin
          if (chain_bit) begin
            state_q <= LOCKED;
            owner_q <= gnt_idx;
            carry_q <= sum_full[W];
          end
        end
        LOCKED: begin
          if (chain_bit) begin
            carry_q <= sum_full[W];
          end else begin
            state_q <= IDLE;
            carry_q <= 1'b0;
          end
        end
      endcase
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (both ADDER_CHAIN_EN builds).
module tb_adder_share_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

  adder_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned lane;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_rsp(input string nm, input int unsigned id, input logic [15:0] sum,
                           input logic cout);
    check({nm, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    check({nm, ".id"},    32'(bus.rsp_id),    32'(id));
    check({nm, ".sum"},   32'(bus.rsp_sum),   32'(sum));
    check({nm, ".cout"},  32'(bus.rsp_cout),  32'(cout));
  endtask

  task automatic set_lane(input int unsigned l, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic chain);
    bus.req_a[l*W +: W] = a;
    bus.req_b[l*W +: W] = b;
    bus.req_cin[l]      = cin;
    bus.req_chain[l]    = chain;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
    vecs[2] = '{2, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{3, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[5] = '{3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[6] = '{1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_chain = '0;
    bus.rsp_ready = 1'b1;

    #12;
    check("reset.valid", 32'(bus.rsp_valid), 32'd0);
    check("reset.sum",   32'(bus.rsp_sum),   32'd0);
    check("reset.cout",  32'(bus.rsp_cout),  32'd0);
    check("reset.id",    32'(bus.rsp_id),    32'd0);
    check("reset.ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // Single-lane transactions from the table
    for (int i = 0; i < 7; i++) begin
      set_lane(vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      bus.req_valid = 4'(1 << vecs[i].lane);
      #1;
      check($sformatf("vec%0d.ready", i), 32'(bus.req_ready), 32'(1 << vecs[i].lane));
      step();
      bus.req_valid = '0;
      check_rsp($sformatf("vec%0d", i), vecs[i].lane, vecs[i].sum, vecs[i].cout);
    end

    // Async reset with a pending response; pointer (now 2) must return to 0
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(bus.rsp_valid), 32'd0);
    check("arst.sum",   32'(bus.rsp_sum),   32'd0);
    check("arst.id",    32'(bus.rsp_id),    32'd0);
    rst_n = 1'b1;
    step();

    // All lanes valid, rsp_ready high: 0,1,2,3,0
    for (int unsigned l = 0; l < NREQ; l++)
      set_lane(l, 16'(16'h1000 * (l + 1)), 16'(l), 1'b0, 1'b0);
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      int unsigned e;
      e = 32'(k % 4);
      #1;
      check($sformatf("rr%0d.ready", k), 32'(bus.req_ready), 32'(1 << e));
      step();
      check_rsp($sformatf("rr%0d", k), e, 16'(16'h1000 * (e + 1) + e), 1'b0);
    end

    // Backpressure for 3 cycles: response and pointer frozen
    bus.rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d.ready", k), 32'(bus.req_ready), 32'd0);
      step();
      check_rsp($sformatf("bp%0d", k), 0, 16'h1000, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release.ready", 32'(bus.req_ready), 32'b0010);
    step();
    check_rsp("bp_release", 1, 16'h2001, 1'b0);
    bus.req_valid = '0;
    step();
    check("drain.valid", 32'(bus.rsp_valid), 32'd0);
    check("drain.sum",   32'(bus.rsp_sum),   32'h2001);
    check("drain.id",    32'(bus.rsp_id),    32'd1);

    // Chain sequence on lane 2 with lanes 0,1 competing (pointer is 2)
    set_lane(0, 16'h0005, 16'h0003, 1'b0, 1'b0);
    set_lane(1, 16'h0010, 16'h0020, 1'b1, 1'b0);
    set_lane(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    bus.req_valid = 4'b0111;
    #1;
    check("ch0.ready", 32'(bus.req_ready), 32'b0100);
    step();
    check_rsp("ch0", 2, 16'h0000, 1'b1);
    set_lane(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1;
`ifdef ADDER_CHAIN_EN
    check("ch1.ready", 32'(bus.req_ready), 32'b0100);
    step();
    check_rsp("ch1", 2, 16'h0001, 1'b0);
    check("ch2.ready", 32'(bus.req_ready), 32'b0001);
    step();
    check_rsp("ch2", 0, 16'h0008, 1'b0);
`else
    check("nc1.ready", 32'(bus.req_ready), 32'b0001);
    step();
    check_rsp("nc1", 0, 16'h0008, 1'b0);
    check("nc2.ready", 32'(bus.req_ready), 32'b0010);
    step();
    check_rsp("nc2", 1, 16'h0031, 1'b0);
    check("nc3.ready", 32'(bus.req_ready), 32'b0100);
    step();
    check_rsp("nc3", 2, 16'h0000, 1'b0);
`endif
    bus.req_valid = '0;
    step();
    check("end.valid", 32'(bus.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
